adt7420_responder: RTL

I2C target model of the ADT7420 temperature sensor, the responder on the other end of the bus driven by `i2c_master`. It samples SCL/SDA with the system clock and answers register-pointer writes and temperature/ID reads at address 0x4B. The returned temperature comes from a parallel input, so benches and loopback builds can feed controlled values into the temperature → TRNG path without the physical sensor.

---
 rtl/adt7420_responder_if.sv | 10 +
 rtl/adt7420_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_responder_if.sv
// I2C pin bundle between a bus master and the ADT7420 responder model.
// SCL and SDA_IN are the resolved bus levels; SDA_OE is the target's open-drain pull-down.
interface adt7420_responder_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OE;

  modport master (output SCL, output SDA_IN, input SDA_OE);
  modport slave  (input SCL, input SDA_IN, output SDA_OE);
endinterface

// File: rtl/adt7420_responder.sv
// ADT7420 I2C target model: pointer writes, temperature/ID reads, coherent shadow of TEMP_IN.
// Optional ADT_NOISE_EN adds LFSR noise on bit 3 of the latched LSB.
module adt7420_responder #(
  parameter logic [6:0] ADDR   = 7'h4B,
  parameter logic [7:0] DEV_ID = 8'hCB
) (
  input  logic                       SCLK,
  input  logic                       RST,
  adt7420_responder_if.slave         bus,
  input  logic [15:0]                TEMP_IN,
  output logic                       BUSY,
  output logic                       ADDR_HIT,
  output logic                       XFER_DONE,
  output logic [7:0]                 PTR
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StPtr, StWdata, StWack, StRdata, StMack
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        full_q, full_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] shadow_q, shadow_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        addr_hit_q, addr_hit_d;
  logic        xfer_done_q, xfer_done_d;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rd_byte;
  logic [15:0] noise;

`ifdef ADT_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign noise  = {12'h000, lfsr_q[0], 3'b000};

  always_ff @(posedge SCLK) begin
    if (RST) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign noise = 16'h0000;
`endif

  always_ff @(posedge SCLK) begin
    if (RST) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_p_q  <= 1'b1;
    end else begin
      scl_s1_q <= bus.SCL;
      scl_s2_q <= scl_s1_q;
      scl_p_q  <= scl_s2_q;
      sda_s1_q <= bus.SDA_IN;
      sda_s2_q <= sda_s1_q;
      sda_p_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q & scl_p_q;
  // SCL must be high on both sides of the SDA edge so a data change at SCL fall never looks
  // like a bus condition.
  assign start_det = scl_s2_q & scl_p_q & ~sda_s2_q & sda_p_q;
  assign stop_det  = scl_s2_q & scl_p_q & sda_s2_q & ~sda_p_q;

  always_comb begin
    rd_byte = 8'h00;
    unique case (ptr_q)
      8'h00:   rd_byte = shadow_q[15:8];
      8'h01:   rd_byte = shadow_q[7:0];
      8'h0B:   rd_byte = DEV_ID;
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    full_d      = full_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    ptr_d       = ptr_q;
    shadow_d    = shadow_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addr_hit_d  = 1'b0;
    xfer_done_d = 1'b0;

    if (stop_det) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      xfer_done_d = busy_q;
    end else if (start_det) begin
      state_d   = StAddr;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) full_d = 1'b1;
          end else if (scl_fall && full_q) begin
            full_d    = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == StAddr) begin
              if (rx_q[7:1] == ADDR) begin
                state_d    = StAddrAck;
                sda_oe_d   = 1'b1;
                addr_hit_d = 1'b1;
                busy_d     = 1'b1;
                rw_d       = rx_q[0];
                // Latch both temperature bytes together so MSB/LSB of one read match.
                if (rx_q[0]) shadow_d = TEMP_IN ^ noise;
              end else begin
                state_d = StIdle;
              end
            end else begin
              if (state_q == StPtr) ptr_d = rx_q;
              state_d  = StWack;
              sda_oe_d = 1'b1;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            full_d    = 1'b0;
            if (rw_q) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = StRdata;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StPtr;
            end
          end
        end
        StWack: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StWdata;
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) full_d = 1'b1;
          end else if (scl_fall) begin
            if (full_q) begin
              full_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = StMack;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        StMack: begin
          if (scl_rise) begin
            ack_d = ~sda_s2_q;
            ptr_d = ptr_q + 8'd1;
          end else if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (ack_q) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = StRdata;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      full_q      <= 1'b0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      ptr_q       <= 8'h00;
      shadow_q    <= 16'h0000;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_hit_q  <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      full_q      <= full_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      ptr_q       <= ptr_d;
      shadow_q    <= shadow_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addr_hit_q  <= addr_hit_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign bus.SDA_OE = sda_oe_q;
  assign BUSY       = busy_q;
  assign ADDR_HIT   = addr_hit_q;
  assign XFER_DONE  = xfer_done_q;
  assign PTR        = ptr_q;

endmodule
